// File: rtl/acortex_pcm_buf_mc.sv
// ---------------------------------------------------------------------------
// acortex_pcm_buf_mc
//
// Multi-channel ping-pong PCM capture buffer. Deserialised codec samples,
// each tagged with a channel index, are written frame by frame into one
// bank while the consumer (fgyrus) reads the other bank. Each frame is one
// sample per channel, always in the order ch0, ch1, ... ch(N-1).
//
// Optional feature: define ACORTEX_PCM_PEAK_EN to build a per-channel
// |peak| tracker whose result is published on peak_vec_o at each bank swap.
// Without it, peak_vec_o is tied to zero and no peak logic is built.
//
// Ports
//   clk_i          system clock
//   rst_i          synchronous reset, active-high
//   cap_en_i       capture enable; low forces the writer back to IDLE
//   smpl_valid_i   sample strobe, one cycle per sample
//   smpl_chan_i    channel index of the sample
//   smpl_data_i    signed sample
//   pcm_rdy_o      read bank is full and owned by the consumer
//   pcm_ack_i      consumer is done with the read bank
//   pcm_addr_i     read address {chan, idx}
//   pcm_rdata_o    read data, one cycle after pcm_addr_i
//   pcm_bank_o     bank currently exposed to the reader
//   drop_cnt_o     samples dropped while both banks were full (saturating)
//   align_err_o    one-cycle pulse on a channel-order violation
//   peak_vec_o     per-channel |peak| of the read bank, ch0 at the LSBs
//   dbg_state_o    writer state: 0 IDLE, 1 SYNC, 2 FILL, 3 HOLD
//
// Bank handshake (rdy/ack):
//   pcm_rdy_o rises the cycle after a full bank is handed to the reader.
//   The reader owns bank pcm_bank_o until it pulses pcm_ack_i while
//   pcm_rdy_o is high. An ack that coincides with a swap keeps pcm_rdy_o
//   high (the reader now owns the freshly filled bank); otherwise the ack
//   drops pcm_rdy_o on the next cycle. An ack while pcm_rdy_o is low is
//   ignored. The writer never targets the bank the reader owns.
// ---------------------------------------------------------------------------
module acortex_pcm_buf_mc #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_W     = 32,
    parameter int NUM_SAMPLES  = 128,
    localparam int CH_W        = $clog2(NUM_CHANNELS),
    localparam int IDX_W       = $clog2(NUM_SAMPLES)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cap_en_i,
    input  logic                             smpl_valid_i,
    input  logic [CH_W-1:0]                  smpl_chan_i,
    input  logic [SAMPLE_W-1:0]              smpl_data_i,
    output logic                             pcm_rdy_o,
    input  logic                             pcm_ack_i,
    input  logic [CH_W+IDX_W-1:0]            pcm_addr_i,
    output logic [SAMPLE_W-1:0]              pcm_rdata_o,
    output logic                             pcm_bank_o,
    output logic [15:0]                      drop_cnt_o,
    output logic                             align_err_o,
    output logic [NUM_CHANNELS*SAMPLE_W-1:0] peak_vec_o,
    output logic [1:0]                       dbg_state_o
);

    localparam int MEM_DEPTH = 2 ** (1 + CH_W + IDX_W);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNELS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_FILL = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CH_W-1:0]     exp_chan_q, exp_chan_d;
    logic                wr_bank_q, wr_bank_d;
    logic                pcm_bank_q, pcm_bank_d;
    logic                pcm_rdy_q, pcm_rdy_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                align_err_q, align_err_d;
    logic [SAMPLE_W-1:0] pcm_rdata_q;

    // Write port of the sample memory, decoded by the writer FSM.
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic                swap;

    // Storage: {bank, chan, idx}. Not reset; contents only matter once a
    // full bank has been handed to the reader.
    logic [SAMPLE_W-1:0] mem_q [MEM_DEPTH];

    // -----------------------------------------------------------------------
    // Writer FSM: next state and outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        exp_chan_d  = exp_chan_q;
        wr_bank_d   = wr_bank_q;
        pcm_bank_d  = pcm_bank_q;
        pcm_rdy_d   = pcm_rdy_q;
        drop_cnt_d  = drop_cnt_q;
        align_err_d = 1'b0;
        wr_en       = 1'b0;
        wr_idx      = idx_q;
        swap        = 1'b0;

        if (!cap_en_i) begin
            // Abort: pointers restart, reader-side state is left alone.
            state_d    = ST_IDLE;
            idx_d      = '0;
            exp_chan_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_SYNC;
                end

                ST_SYNC: begin
                    // Hunt for a frame start; anything else is discarded.
                    if (smpl_valid_i && (smpl_chan_i == '0)) begin
                        wr_en      = 1'b1;
                        wr_idx     = '0;
                        idx_d      = '0;
                        exp_chan_d = CH_W'(1);
                        state_d    = ST_FILL;
                    end
                end

                ST_FILL: begin
                    if (smpl_valid_i) begin
                        if (smpl_chan_i == exp_chan_q) begin
                            wr_en = 1'b1;
                            if (exp_chan_q == LAST_CH) begin
                                exp_chan_d = '0;
                                if (idx_q == LAST_IDX) begin
                                    // Bank full: hand it over now if the
                                    // reader's bank is free or being released.
                                    if (!pcm_rdy_q || pcm_ack_i) begin
                                        swap = 1'b1;
                                    end else begin
                                        state_d = ST_HOLD;
                                    end
                                end else begin
                                    idx_d = idx_q + IDX_W'(1);
                                end
                            end else begin
                                exp_chan_d = exp_chan_q + CH_W'(1);
                            end
                        end else begin
                            // Out-of-order channel: the partial frame at idx_q
                            // is abandoned. A ch0 sample restarts the frame in
                            // place; any other channel forces a resync.
                            align_err_d = 1'b1;
                            if (smpl_chan_i == '0) begin
                                wr_en      = 1'b1;
                                exp_chan_d = CH_W'(1);
                            end else begin
                                state_d = ST_SYNC;
                            end
                        end
                    end
                end

                ST_HOLD: begin
                    // Both banks full: every incoming sample is lost,
                    // including one that lands on the releasing ack cycle.
                    if (smpl_valid_i && (drop_cnt_q != 16'hFFFF)) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                    if (pcm_ack_i) begin
                        swap    = 1'b1;
                        state_d = ST_SYNC;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (swap) begin
            pcm_bank_d = wr_bank_q;
            wr_bank_d  = ~wr_bank_q;
            idx_d      = '0;
            exp_chan_d = '0;
            pcm_rdy_d  = 1'b1;
        end else if (pcm_ack_i && pcm_rdy_q) begin
            pcm_rdy_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Writer FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            exp_chan_q  <= '0;
            wr_bank_q   <= 1'b1;
            pcm_bank_q  <= 1'b0;
            pcm_rdy_q   <= 1'b0;
            drop_cnt_q  <= '0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            exp_chan_q  <= exp_chan_d;
            wr_bank_q   <= wr_bank_d;
            pcm_bank_q  <= pcm_bank_d;
            pcm_rdy_q   <= pcm_rdy_d;
            drop_cnt_q  <= drop_cnt_d;
            align_err_q <= align_err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Sample memory: one write port (writer bank), one registered read port
    // (reader bank). The two ports never address the same bank.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (wr_en && !rst_i) begin
            mem_q[{wr_bank_q, smpl_chan_i, wr_idx}] <= smpl_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pcm_rdata_q <= '0;
        end else begin
            pcm_rdata_q <= mem_q[{pcm_bank_q, pcm_addr_i}];
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel peak magnitude
    // -----------------------------------------------------------------------
`ifdef ACORTEX_PCM_PEAK_EN
    localparam logic [SAMPLE_W-1:0] MIN_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MAX_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

    logic [SAMPLE_W-1:0]             wr_abs;
    logic [SAMPLE_W-1:0]             peak_run_q [NUM_CHANNELS];
    logic [SAMPLE_W-1:0]             peak_upd   [NUM_CHANNELS];
    logic [NUM_CHANNELS*SAMPLE_W-1:0] peak_vec_q;

    // |x| with the most negative value clamped, so the result always fits
    // in SAMPLE_W-1 magnitude bits.
    always_comb begin
        if (!smpl_data_i[SAMPLE_W-1]) begin
            wr_abs = smpl_data_i;
        end else if (smpl_data_i == MIN_NEG) begin
            wr_abs = MAX_POS;
        end else begin
            wr_abs = -smpl_data_i;
        end
    end

    // Every written sample counts, even one whose frame is later abandoned.
    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            peak_upd[c] = peak_run_q[c];
            if (wr_en && (smpl_chan_i == CH_W'(c)) && (wr_abs > peak_run_q[c])) begin
                peak_upd[c] = wr_abs;
            end
        end
    end

    // On a swap the published value includes the sample written that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                peak_run_q[c] <= '0;
            end
            peak_vec_q <= '0;
        end else if (swap) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                peak_vec_q[c*SAMPLE_W +: SAMPLE_W] <= peak_upd[c];
                peak_run_q[c]                      <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                peak_run_q[c] <= peak_upd[c];
            end
        end
    end

    assign peak_vec_o = peak_vec_q;
`else
    assign peak_vec_o = '0;
`endif

    assign pcm_rdy_o   = pcm_rdy_q;
    assign pcm_rdata_o = pcm_rdata_q;
    assign pcm_bank_o  = pcm_bank_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign align_err_o = align_err_q;
    assign dbg_state_o = state_q;

endmodule
